// File: rtl/pc_sequencer.sv
// Next-PC select for the pipelined MIPS core, plus interrupt pending/EPC/CAUSE state.
// Optional misaligned-target trap is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] INT_VEC   = 32'h0000_4180,
   parameter int          NUM_IRQ   = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pc_cur,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_tgt,
   input  logic               jump,
   input  logic [31:0]        jump_tgt,
   input  logic               eret,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   output logic [31:0]        pc_next,
   output logic               pc_wr,
   output logic               flush,
   output logic [31:0]        epc,
   output logic [NUM_IRQ-1:0] cause,
   output logic               in_isr
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic               addr_err
`endif
);

   typedef enum logic {RUN, HANDLER} state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] pend;
   logic               do_eret;
   logic               do_int;
   logic               do_exc;
   logic [31:0]        tgt;

   // Entry is deferred under jump/branch so the delay slot is not lost.
   always_comb begin
      do_eret = (state == HANDLER) && eret && !stall;
      do_int  = (state == RUN) && (|pend) && !jump && !branch_taken && !stall;
      if (do_eret)
         tgt = epc;
      else if (jump)
         tgt = jump_tgt;
      else if (branch_taken)
         tgt = branch_tgt;
      else
         tgt = pc_cur + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
      do_exc = !stall && !do_int && (do_eret || jump || branch_taken) && (tgt[1:0] != 2'b00);
`else
      do_exc = 1'b0;
`endif
      pc_next = (do_int || do_exc) ? INT_VEC : tgt;
      pc_wr   = !stall;
      flush   = do_eret || do_int || do_exc;
      if (rst) begin
         pc_next = RESET_VEC;
         pc_wr   = 1'b0;
         flush   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         pend  <= '0;
         epc   <= '0;
         cause <= '0;
`ifdef PC_ALIGN_CHECK_EN
         addr_err <= 1'b0;
`endif
      end else begin
         // Lines arriving in the entry cycle survive the clear.
         pend <= (do_int ? '0 : pend) | (irq & irq_mask);
         if (do_exc) begin
            epc   <= pc_cur;
            state <= HANDLER;
`ifdef PC_ALIGN_CHECK_EN
            addr_err <= 1'b1;
`endif
         end else if (do_int) begin
            epc   <= pc_cur;
            cause <= pend;
            state <= HANDLER;
         end else if (do_eret) begin
            state <= RUN;
`ifdef PC_ALIGN_CHECK_EN
            addr_err <= 1'b0;
`endif
         end
      end
   end

   assign in_isr = (state == HANDLER);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer against a behavioural next-PC model.
module tb_pc_sequencer;
   localparam int          NUM_IRQ   = 6;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] INT_VEC   = 32'h0000_4180;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [31:0]        pc_cur = '0;
   logic               stall = 1'b0;
   logic               branch_taken = 1'b0;
   logic [31:0]        branch_tgt = '0;
   logic               jump = 1'b0;
   logic [31:0]        jump_tgt = '0;
   logic               eret = 1'b0;
   logic [NUM_IRQ-1:0] irq = '0;
   logic [NUM_IRQ-1:0] irq_mask = '0;
   logic [31:0]        pc_next;
   logic               pc_wr;
   logic               flush;
   logic [31:0]        epc;
   logic [NUM_IRQ-1:0] cause;
   logic               in_isr;
`ifdef PC_ALIGN_CHECK_EN
   logic               addr_err;
`endif

   pc_sequencer #(.RESET_VEC(RESET_VEC), .INT_VEC(INT_VEC), .NUM_IRQ(NUM_IRQ)) dut (
      .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall),
      .branch_taken(branch_taken), .branch_tgt(branch_tgt),
      .jump(jump), .jump_tgt(jump_tgt), .eret(eret),
      .irq(irq), .irq_mask(irq_mask),
      .pc_next(pc_next), .pc_wr(pc_wr), .flush(flush),
      .epc(epc), .cause(cause), .in_isr(in_isr)
`ifdef PC_ALIGN_CHECK_EN
      , .addr_err(addr_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]        pc;
      logic               chk_pc;
      logic               wr;
      logic               fl;
      logic [31:0]        epc;
      logic [NUM_IRQ-1:0] cause;
      logic               isr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model state: architectural view only.
   bit                 m_hnd;
   logic [NUM_IRQ-1:0] m_pend;
   logic [31:0]        m_epc;
   logic [NUM_IRQ-1:0] m_cause;
   logic [31:0]        last_pc;
   logic               last_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.chk_pc) chk("pc_next", pc_next, e.pc);
         chk("pc_wr", {31'd0, pc_wr}, {31'd0, e.wr});
         chk("flush", {31'd0, flush}, {31'd0, e.fl});
         chk("epc", epc, e.epc);
         chk("cause", {{(32-NUM_IRQ){1'b0}}, cause}, {{(32-NUM_IRQ){1'b0}}, e.cause});
         chk("in_isr", {31'd0, in_isr}, {31'd0, e.isr});
      end
   end

   // Predict this cycle's outputs, then advance the model across the clock edge.
   task automatic step();
      exp_t e;
      int   kind;
      kind = 0;
      if (rst) begin
         m_hnd = 0; m_pend = '0; m_epc = '0; m_cause = '0;
         e.pc = RESET_VEC; e.chk_pc = 1; e.wr = 0; e.fl = 0;
      end else begin
         e.wr = !stall; e.fl = 0; e.chk_pc = !stall; e.pc = '0;
         if (stall) e.pc = '0;
         else if (m_hnd && eret) begin kind = 1; e.pc = m_epc; e.fl = 1; end
         else if (!m_hnd && m_pend != 0 && !jump && !branch_taken) begin
            kind = 2; e.pc = INT_VEC; e.fl = 1;
         end
         else if (jump) e.pc = jump_tgt;
         else if (branch_taken) e.pc = branch_tgt;
         else e.pc = pc_cur + 32'd4;
      end
      e.epc = m_epc; e.cause = m_cause; e.isr = m_hnd;
      q.push_back(e);
      last_pc = e.pc; last_wr = e.wr;
      @(posedge clk);
      if (!rst) begin
         if (kind == 2) begin
            m_epc = pc_cur; m_cause = m_pend; m_pend = irq & irq_mask; m_hnd = 1;
         end else begin
            m_pend = m_pend | (irq & irq_mask);
            if (kind == 1) m_hnd = 0;
         end
      end
      #1;
   endtask

   initial begin
      @(posedge clk); #1;
      // reset
      step(); step();
      rst = 0; pc_cur = 32'h0; step();
      // sequential, stall, wrap
      pc_cur = 32'h100; stall = 1; step();
      stall = 0; step();
      pc_cur = 32'hFFFF_FFFC; step();
      // jump beats branch
      jump = 1; jump_tgt = 32'h2000; branch_taken = 1; branch_tgt = 32'h3000; step();
      jump = 0; branch_taken = 1; step();
      branch_taken = 0;
      // interrupt entry
      irq_mask = '1; irq = 6'b000100; pc_cur = 32'h400; step();
      irq = 0; step();
      pc_cur = INT_VEC; step();
      // irq in handler held, eret returns, then re-entry
      irq = 6'b000001; pc_cur = 32'h4184; step();
      irq = 0; step();
      eret = 1; step();
      eret = 0; pc_cur = 32'h400; step();
      pc_cur = INT_VEC; step();
      eret = 1; step();
      eret = 0;
      // deferral under jump
      irq = 6'b000010; pc_cur = 32'h800; step();
      irq = 0; jump = 1; jump_tgt = 32'h1230; step();
      jump = 0; pc_cur = 32'h1230; step();
      eret = 1; step();
      eret = 0;
      // masked line, eret in RUN ignored
      irq_mask = 6'b110111; irq = 6'b001000; pc_cur = 32'h600; step();
      irq = 0; eret = 1; step();
      eret = 0; step();
      // reset mid-handler
      irq_mask = '1; irq = 6'b100000; step();
      irq = 0; step();
      rst = 1; step();
      rst = 0; pc_cur = RESET_VEC; step();
      // randomised traffic, PC register closed around the expected pc_next
      for (int i = 0; i < 3000; i++) begin
         stall        = ($urandom_range(0, 6) == 0);
         jump         = ($urandom_range(0, 4) == 0);
         branch_taken = ($urandom_range(0, 4) == 0);
         eret         = ($urandom_range(0, 3) == 0);
         jump_tgt     = $urandom & 32'hFFFF_FFFC;
         branch_tgt   = $urandom & 32'hFFFF_FFFC;
         irq          = ($urandom_range(0, 9) == 0) ? NUM_IRQ'($urandom) : '0;
         irq_mask     = NUM_IRQ'($urandom);
         rst          = ($urandom_range(0, 499) == 0);
         step();
         rst = 0;
         if (last_wr) pc_cur = last_pc;
      end
      @(negedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
